// File: rtl/branch_resolve_if.sv
// Bundle between the ID-stage branch resolver and the pipeline around it.
// The master side drives operands, selects and hazard inputs; the slave side is the resolver.
interface branch_resolve_if #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  flush;
    logic                  branch_valid;
    logic                  branch_ne;
    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] rs_data;
    logic [DATA_WIDTH-1:0] rt_data;
    logic [DATA_WIDTH-1:0] ex_result;
    logic [DATA_WIDTH-1:0] ex_mem_result;
    logic [DATA_WIDTH-1:0] mem_mux;
    logic [1:0]            FwdCtrl_1;
    logic [1:0]            FwdCtrl_2;
    logic                  ID_EX_MemRead;
    logic                  EX_MEM_MemRead;
    logic                  stall;
    logic                  bubble;
    logic                  pc_src;
    logic [DATA_WIDTH-1:0] branch_target;
    logic                  flush_if_id;
    logic [CNT_WIDTH-1:0]  branch_cnt;
    logic [CNT_WIDTH-1:0]  taken_cnt;
    logic [CNT_WIDTH-1:0]  stall_cycles;

    modport master (
        output flush, branch_valid, branch_ne, pc_plus4, imm_ext, rs_data, rt_data,
               ex_result, ex_mem_result, mem_mux, FwdCtrl_1, FwdCtrl_2,
               ID_EX_MemRead, EX_MEM_MemRead,
        input  stall, bubble, pc_src, branch_target, flush_if_id,
               branch_cnt, taken_cnt, stall_cycles
    );

    modport slave (
        input  flush, branch_valid, branch_ne, pc_plus4, imm_ext, rs_data, rt_data,
               ex_result, ex_mem_result, mem_mux, FwdCtrl_1, FwdCtrl_2,
               ID_EX_MemRead, EX_MEM_MemRead,
        output stall, bubble, pc_src, branch_target, flush_if_id,
               branch_cnt, taken_cnt, stall_cycles
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// ID-stage beq/bne resolver with stall-countdown FSM and saturating perf counters.
// Define BRANCH_EX_FWD_EN to resolve directly from ex_result for non-load EX producers.
//
// state   | meaning
// IDLE    | no branch pending; resolve now or start a stall
// STALL   | waiting for a producer; stall/bubble asserted
// RESOLVE | operands ready; decide the branch and return to IDLE
module branch_resolve_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input logic             clk,
    input logic             reset,
    branch_resolve_if.slave bus
);
    typedef enum logic [1:0] {IDLE, STALL, RESOLVE} state_t;

    state_t                state_q, state_d;
    logic [1:0]            count_q, count_d;
    logic [CNT_WIDTH-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_WIDTH-1:0]  taken_cnt_q, taken_cnt_d;
    logic [CNT_WIDTH-1:0]  stall_cycles_q, stall_cycles_d;

    logic [DATA_WIDTH-1:0] op_a, op_b;
    logic                  taken;
    logic                  sel_ex, sel_mem;
    logic                  load_ex_haz, load_mem_haz, alu_ex_haz, hazard;
    logic [1:0]            stall_len;
    logic                  stall_o, resolve;

    function automatic logic [DATA_WIDTH-1:0] fwd_mux(input logic [1:0] sel,
                                                      input logic [DATA_WIDTH-1:0] reg_val);
        case (sel)
            2'b01:   return bus.ex_mem_result;
            2'b10:   return bus.mem_mux;
            2'b11:   return bus.ex_result;
            default: return reg_val;
        endcase
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign op_a  = fwd_mux(bus.FwdCtrl_1, bus.rs_data);
    assign op_b  = fwd_mux(bus.FwdCtrl_2, bus.rt_data);
    assign taken = bus.branch_ne ^ (op_a == op_b);

    assign bus.branch_target = bus.pc_plus4 + (bus.imm_ext << 2);

    assign sel_ex       = (bus.FwdCtrl_1 == 2'b11) || (bus.FwdCtrl_2 == 2'b11);
    assign sel_mem      = (bus.FwdCtrl_1 == 2'b01) || (bus.FwdCtrl_2 == 2'b01);
    assign load_ex_haz  = sel_ex && bus.ID_EX_MemRead;
    assign load_mem_haz = sel_mem && bus.EX_MEM_MemRead;
`ifdef BRANCH_EX_FWD_EN
    assign alu_ex_haz   = 1'b0;
`else
    assign alu_ex_haz   = sel_ex;
`endif
    assign hazard    = load_ex_haz || load_mem_haz || alu_ex_haz;
    assign stall_len = load_ex_haz ? 2'd2 : 2'd1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        stall_o = 1'b0;
        resolve = 1'b0;
        if (reset || bus.flush) begin
            state_d = IDLE;
            count_d = 2'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.branch_valid) begin
                        if (hazard) begin
                            stall_o = 1'b1;
                            count_d = stall_len - 2'd1;
                            state_d = (stall_len == 2'd1) ? RESOLVE : STALL;
                        end else begin
                            resolve = 1'b1;
                        end
                    end
                end
                STALL: begin
                    // a vanished branch is treated exactly like a flush
                    if (!bus.branch_valid) begin
                        state_d = IDLE;
                        count_d = 2'd0;
                    end else begin
                        stall_o = 1'b1;
                        count_d = (count_q == 2'd0) ? 2'd0 : count_q - 2'd1;
                        if (count_d == 2'd0) state_d = RESOLVE;
                    end
                end
                RESOLVE: begin
                    state_d = IDLE;
                    count_d = 2'd0;
                    resolve = bus.branch_valid;
                end
                default: begin
                    state_d = IDLE;
                    count_d = 2'd0;
                end
            endcase
        end
    end

    always_comb begin
        branch_cnt_d   = branch_cnt_q;
        taken_cnt_d    = taken_cnt_q;
        stall_cycles_d = stall_cycles_q;
        if (resolve) begin
            branch_cnt_d = sat_inc(branch_cnt_q);
            if (taken) taken_cnt_d = sat_inc(taken_cnt_q);
        end
        if (stall_o) stall_cycles_d = sat_inc(stall_cycles_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            count_q        <= 2'd0;
            branch_cnt_q   <= '0;
            taken_cnt_q    <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            branch_cnt_q   <= branch_cnt_d;
            taken_cnt_q    <= taken_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.stall        = stall_o;
    assign bus.bubble       = stall_o;
    assign bus.pc_src       = resolve && taken;
    assign bus.flush_if_id  = resolve && taken;
    assign bus.branch_cnt   = branch_cnt_q;
    assign bus.taken_cnt    = taken_cnt_q;
    assign bus.stall_cycles = stall_cycles_q;

`ifndef SYNTHESIS
    // the forwarding unit must have cleared every hazard by the time we resolve
    a_no_hazard_in_resolve: assert property (@(posedge clk) disable iff (reset)
        (state_q == RESOLVE && bus.branch_valid && !bus.flush) |-> !hazard);
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed vectors push hand-computed
// expectations tagged with their cycle; a monitor pops and compares each cycle.
module tb_branch_resolve_unit;
    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   failures;

    branch_resolve_if #(.DATA_WIDTH(32), .CNT_WIDTH(16)) bus ();

    branch_resolve_unit #(.DATA_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef BRANCH_EX_FWD_EN
    localparam int EXS = 0;
`else
    localparam int EXS = 1;
`endif
    localparam int SC0 = 2 + EXS;

    typedef struct {
        logic        rst, fl, bv, ne;
        logic [31:0] pc, imm, rs, rt, exr, exmr, memm;
        logic [1:0]  f1, f2;
        logic        idld, exld;
    } vin_t;

    typedef struct {
        int          cyc;
        int          mode;
        string       tag;
        int          stall, bubble, pc_src, fiid;
        logic [31:0] tgt;
        int          bc, tc, sc;
    } exp_t;

    exp_t exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic vin_t idle_in();
        vin_t v;
        v.rst = 0; v.fl = 0; v.bv = 0; v.ne = 0;
        v.pc = 32'h100; v.imm = 32'h3;
        v.rs = 0; v.rt = 0; v.exr = 0; v.exmr = 0; v.memm = 0;
        v.f1 = 2'b00; v.f2 = 2'b00; v.idld = 0; v.exld = 0;
        return v;
    endfunction

    // mode 0: no check, 1: control outputs + target, 2: also perf counters
    task automatic drive(input vin_t v, input string tag, input int mode,
                         input int st, input int bub, input int pcs, input int fi,
                         input logic [31:0] tgt, input int bc, input int tc, input int sc);
        exp_t e;
        @(posedge clk);
        #1;
        reset              = v.rst;
        bus.flush          = v.fl;
        bus.branch_valid   = v.bv;
        bus.branch_ne      = v.ne;
        bus.pc_plus4       = v.pc;
        bus.imm_ext        = v.imm;
        bus.rs_data        = v.rs;
        bus.rt_data        = v.rt;
        bus.ex_result      = v.exr;
        bus.ex_mem_result  = v.exmr;
        bus.mem_mux        = v.memm;
        bus.FwdCtrl_1      = v.f1;
        bus.FwdCtrl_2      = v.f2;
        bus.ID_EX_MemRead  = v.idld;
        bus.EX_MEM_MemRead = v.exld;
        if (mode != 0) begin
            e.cyc = cyc; e.mode = mode; e.tag = tag;
            e.stall = st; e.bubble = bub; e.pc_src = pcs; e.fiid = fi;
            e.tgt = tgt; e.bc = bc; e.tc = tc; e.sc = sc;
            exp_q.push_back(e);
        end
    endtask

    task automatic cmp(input string tag, input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%0h required=%0h", tag, nm, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.cyc < cyc) begin
                    checks++;
                    failures++;
                    $display("FAIL %s.missed actual_cycle=%0d required_cycle=%0d", e.tag, cyc, e.cyc);
                end else begin
                    cmp(e.tag, "stall",         32'(bus.stall),       32'(e.stall));
                    cmp(e.tag, "bubble",        32'(bus.bubble),      32'(e.bubble));
                    cmp(e.tag, "pc_src",        32'(bus.pc_src),      32'(e.pc_src));
                    cmp(e.tag, "flush_if_id",   32'(bus.flush_if_id), 32'(e.fiid));
                    cmp(e.tag, "branch_target", bus.branch_target,    e.tgt);
                    if (e.mode == 2) begin
                        cmp(e.tag, "branch_cnt",   32'(bus.branch_cnt),   32'(e.bc));
                        cmp(e.tag, "taken_cnt",    32'(bus.taken_cnt),    32'(e.tc));
                        cmp(e.tag, "stall_cycles", 32'(bus.stall_cycles), 32'(e.sc));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1500000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        vin_t v;
        checks   = 0;
        failures = 0;

        // reset with a load hazard present: everything must stay quiet
        v = idle_in(); v.rst = 1; v.bv = 1; v.f1 = 2'b11; v.idld = 1;
        drive(v, "rst0", 1, 0, 0, 0, 0, 32'h10C, 0, 0, 0);
        drive(v, "rst1", 2, 0, 0, 0, 0, 32'h10C, 0, 0, 0);

        // beq, regfile operands, taken in the same cycle
        v = idle_in(); v.bv = 1; v.rs = 5; v.rt = 5;
        drive(v, "t1_beq", 2, 0, 0, 1, 1, 32'h10C, 0, 0, 0);
        v = idle_in();
        drive(v, "t1_idle", 2, 0, 0, 0, 0, 32'h10C, 1, 1, 0);

        // bne with RS from EX/MEM, equal -> not taken
        v = idle_in(); v.bv = 1; v.ne = 1; v.f1 = 2'b01; v.exmr = 7; v.rs = 3; v.rt = 7;
        drive(v, "t2_bne", 2, 0, 0, 0, 0, 32'h10C, 1, 1, 0);

        // load in EX: two stall cycles, then resolve from mem_mux
        v = idle_in(); v.bv = 1; v.f1 = 2'b11; v.idld = 1; v.rt = 9;
        drive(v, "t3_stall0", 2, 1, 1, 0, 0, 32'h10C, 2, 1, 0);
        v = idle_in(); v.bv = 1; v.f1 = 2'b01; v.exld = 1; v.rt = 9;
        drive(v, "t3_stall1", 2, 1, 1, 0, 0, 32'h10C, 2, 1, 1);
        v = idle_in(); v.bv = 1; v.f1 = 2'b10; v.memm = 9; v.rt = 9;
        drive(v, "t3_res", 2, 0, 0, 1, 1, 32'h10C, 2, 1, 2);

        // RT produced by an ALU op in EX
        v = idle_in(); v.bv = 1; v.rs = 4; v.f2 = 2'b11; v.exr = 4;
`ifdef BRANCH_EX_FWD_EN
        drive(v, "t4_fwd", 2, 0, 0, 1, 1, 32'h10C, 3, 2, 2);
`else
        drive(v, "t4_stall", 2, 1, 1, 0, 0, 32'h10C, 3, 2, 2);
        v.f2 = 2'b01; v.exmr = 4; v.exr = 32'h99;
        drive(v, "t4_res", 2, 0, 0, 1, 1, 32'h10C, 3, 2, 3);
`endif
        v = idle_in();
        drive(v, "t4_idle", 2, 0, 0, 0, 0, 32'h10C, 4, 3, SC0);

        // flush in the first STALL cycle aborts; next branch resolves immediately
        v = idle_in(); v.bv = 1; v.f1 = 2'b11; v.idld = 1;
        drive(v, "t5_haz", 2, 1, 1, 0, 0, 32'h10C, 4, 3, SC0);
        v.fl = 1;
        drive(v, "t5_flush", 2, 0, 0, 0, 0, 32'h10C, 4, 3, SC0 + 1);
        v = idle_in(); v.bv = 1; v.rs = 1; v.rt = 1;
        drive(v, "t5_after", 2, 0, 0, 1, 1, 32'h10C, 4, 3, SC0 + 1);

        // branch_valid dropping mid-stall behaves like flush
        v = idle_in(); v.bv = 1; v.f1 = 2'b11; v.idld = 1;
        drive(v, "t5b_haz", 2, 1, 1, 0, 0, 32'h10C, 5, 4, SC0 + 1);
        v.bv = 0;
        drive(v, "t5b_drop", 2, 0, 0, 0, 0, 32'h10C, 5, 4, SC0 + 2);
        v = idle_in(); v.bv = 1; v.rs = 1; v.rt = 1;
        drive(v, "t5b_after", 2, 0, 0, 1, 1, 32'h10C, 5, 4, SC0 + 2);

        // reset mid-stall: no resolution, counters cleared
        v = idle_in(); v.bv = 1; v.f1 = 2'b11; v.idld = 1;
        drive(v, "t6_haz", 2, 1, 1, 0, 0, 32'h10C, 6, 5, SC0 + 2);
        v.rst = 1;
        drive(v, "t6_rst", 2, 0, 0, 0, 0, 32'h10C, 6, 5, SC0 + 3);
        v = idle_in(); v.bv = 1; v.ne = 1; v.rs = 1; v.rt = 2;
        drive(v, "t6_bne", 2, 0, 0, 1, 1, 32'h10C, 0, 0, 0);
        v = idle_in();
        drive(v, "t6_idle", 2, 0, 0, 0, 0, 32'h10C, 1, 1, 0);

        // load in MEM: one stall, resolve from EX/MEM
        v = idle_in(); v.bv = 1; v.f2 = 2'b01; v.exld = 1; v.rs = 8;
        drive(v, "t7_stall", 2, 1, 1, 0, 0, 32'h10C, 1, 1, 0);
        v.exld = 0; v.exmr = 8;
        drive(v, "t7_res", 2, 0, 0, 1, 1, 32'h10C, 1, 1, 1);
        v = idle_in(); v.bv = 1; v.ne = 1; v.f1 = 2'b10; v.memm = 5; v.rs = 77; v.rt = 5;
        drive(v, "t7_bne_nt", 2, 0, 0, 0, 0, 32'h10C, 2, 2, 1);

        // target wrap-around and negative offset
        v = idle_in(); v.pc = 32'hFFFF_FFF0; v.imm = 32'h8;
        drive(v, "tgt_wrap", 2, 0, 0, 0, 0, 32'h0000_0010, 3, 2, 1);
        v = idle_in(); v.pc = 32'h200; v.imm = 32'hFFFF_FFFF;
        drive(v, "tgt_neg", 2, 0, 0, 0, 0, 32'h0000_01FC, 3, 2, 1);

        // saturation: 65535 taken branches from reset, then one more
        v = idle_in(); v.rst = 1;
        drive(v, "sat_rst", 1, 0, 0, 0, 0, 32'h10C, 0, 0, 0);
        v = idle_in(); v.bv = 1; v.rs = 2; v.rt = 2;
        for (int i = 0; i < 65535; i++) begin
            if (i == 65534)
                drive(v, "sat_last", 2, 0, 0, 1, 1, 32'h10C, 65534, 65534, 0);
            else
                drive(v, "sat_fill", 0, 0, 0, 0, 0, 32'h10C, 0, 0, 0);
        end
        drive(v, "sat_more", 2, 0, 0, 1, 1, 32'h10C, 65535, 65535, 0);
        v = idle_in();
        drive(v, "sat_hold", 2, 0, 0, 0, 0, 32'h10C, 65535, 65535, 0);
        drive(v, "tail", 0, 0, 0, 0, 0, 32'h10C, 0, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain actual_left=%0d required_left=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- ID-stage branch resolver that consumes the branch forwarding selects (FwdCtrl_1/FwdCtrl_2) and the forwarded operand sources, then decides beq/bne in ID.
- Drives PC select, branch target, IF/ID flush, and the load-use / EX-result stall that forwarding alone cannot cover.
- Holds a stall-countdown FSM and saturating performance counters.
- Sits between the IF/ID register and the ID/EX register, beside the hazard logic that freezes PC and IF/ID.

Parameters:
- DATA_WIDTH, 32, operand and PC width.
- CNT_WIDTH, 16, width of each performance counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous active-high reset.
- flush  in  1  external squash (jump/exception); aborts any branch in progress.
- branch_valid  in  1  instruction in ID is a branch.
- branch_ne  in  1  1=bne, 0=beq.
- pc_plus4  in  DATA_WIDTH  PC+4 of the branch.
- imm_ext  in  DATA_WIDTH  sign-extended offset.
- rs_data  in  DATA_WIDTH  register-file RS read.
- rt_data  in  DATA_WIDTH  register-file RT read.
- ex_result  in  DATA_WIDTH  EX-stage ALU output (select 11).
- ex_mem_result  in  DATA_WIDTH  EX/MEM ALU result (select 01).
- mem_mux  in  DATA_WIDTH  WB-stage write-back value (select 10).
- FwdCtrl_1  in  2  RS operand select: 00 regfile, 01 EX/MEM, 10 mem_mux, 11 EX.
- FwdCtrl_2  in  2  RT operand select, same encoding.
- ID_EX_MemRead  in  1  instruction in EX is a load.
- EX_MEM_MemRead  in  1  instruction in MEM is a load.
- stall  out  1  freeze PC and IF/ID.
- bubble  out  1  zero ID/EX control signals.
- pc_src  out  1  1 = take branch_target.
- branch_target  out  DATA_WIDTH  pc_plus4 + (imm_ext << 2).
- flush_if_id  out  1  squash the IF/ID instruction.
- branch_cnt  out  CNT_WIDTH  resolved branches.
- taken_cnt  out  CNT_WIDTH  taken branches.
- stall_cycles  out  CNT_WIDTH  cycles spent in stall.

Behaviour:
- Reset: state=IDLE, counter=0, all perf counters=0. stall, bubble, pc_src, flush_if_id = 0 in the reset cycle.
- Operand mux uses FwdCtrl encoding above. Equal = (opA == opB). taken = branch_ne ? !equal : equal.
- branch_target is combinational and always driven; it is wrap-around modulo 2^DATA_WIDTH.
- Hazard classification in IDLE with branch_valid=1 and flush=0; either operand matching triggers the load:
  - Select 11 with ID_EX_MemRead: load count 2.
  - Else select 01 with EX_MEM_MemRead: load count 1.
  - Else select 11 (ALU in EX): load count 1, unless BRANCH_EX_FWD_EN is defined (see Optional Feature).
  - Otherwise: resolve this cycle.
- States:
  - IDLE: on a hazard, stall=bubble=1 and go to STALL with count-1 remaining. Without a hazard, resolve in the same cycle.
  - STALL: stall=bubble=1, decrement the counter. When the counter is 0 this cycle, go to RESOLVE.
  - RESOLVE: stall=0; evaluate the branch using the current selects; return to IDLE.
- Resolve cycle (IDLE without hazard, or RESOLVE): pc_src=taken and flush_if_id=taken. branch_cnt += 1; taken_cnt += taken.
- Resolution in RESOLVE must not re-detect a hazard. A hazard still present at that point is a protocol error; flag it with a simulation-only assertion.
- flush has priority over everything:
  - Force IDLE and zero the counter.
  - Outputs stall, bubble, pc_src, flush_if_id = 0.
  - No counter updates.
- branch_valid dropping while in STALL is treated as flush.
- Reset mid-stall: IDLE next cycle, no resolution.
- stall_cycles increments in every cycle with stall=1.
- All perf counters saturate at all-ones; they never wrap.
- branch_valid=0 in IDLE: all control outputs 0.

Optional Feature:
- Macro: BRANCH_EX_FWD_EN.
- Defined: select 11 from a non-load uses ex_result directly with no stall. This is the long combinational path.
- Undefined: that case costs one stall cycle. The next cycle the selects become 01 and ex_mem_result is used.
- Load cases are unchanged either way.

Test Plan:
- beq, selects 00, rs_data=rt_data=5 -> same cycle pc_src=1, flush_if_id=1; branch_target = pc_plus4 0x100 + (imm 3<<2) = 0x10C; branch_cnt=1, taken_cnt=1.
- bne, FwdCtrl_1=01, ex_mem_result=7, rt_data=7 -> pc_src=0, no stall, taken_cnt stays 0.
- beq, FwdCtrl_1=11 with ID_EX_MemRead=1 -> stall=1 for exactly 2 cycles. Then selects 10, mem_mux=9, rt=9 -> pc_src=1 in cycle 3; stall_cycles=2.
- FwdCtrl_2=11 from ALU op, ex_result=4 -> macro undefined: 1 stall then resolve via ex_mem_result=4. Macro defined: resolve in cycle 0, stall never asserted.
- Load-in-EX hazard, flush=1 in the first STALL cycle -> next cycle IDLE, stall=0, branch_cnt unchanged. Repeat with reset instead: same result, counters=0.
- Preload taken_cnt to 0xFFFF via 65535 taken branches, issue one more taken branch -> taken_cnt holds 0xFFFF.
